adpll_loop_filter: RTL

Digital proportional-integral loop filter for the ADPLL, directly downstream of the delay-line phase detector. Each valid signed phase-error sample (`pd_clock_cycles`, counted in `fpga_clk_i` cycles) updates a saturating fixed-point integrator. The block emits an unsigned DCO control word three cycles later. Optional lock detection switches the filter from acquisition gains to tracking gains.

---
 rtl/adpll_loop_filter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter
//
// Proportional-integral loop filter for the ADPLL. Each valid signed
// phase-error sample from the delay-line phase detector updates a saturating
// fixed-point integrator. Three cycles later an unsigned DCO control word is
// produced.
//
// Build option: define ADPLL_LOCK_DETECT_EN to include the lock detector.
// When it is enabled, the filter moves from acquisition gains to tracking
// gains once lock is declared. When it is not defined, the filter always
// uses acquisition gains and locked_o is tied to 0.
//
// Ports:
//   fpga_clk_i        - single clock for all logic
//   reset_n_i         - asynchronous active-low reset (release is synchronised)
//   pd_valid_i        - one-cycle strobe, new phase-error sample
//   pd_clock_cycles_i - signed phase error (positive = generated clock lags)
//   hold_i            - freeze the integrator for this sample (prop still applied)
//   ctrl_o            - DCO control word
//   ctrl_valid_o      - one-cycle strobe, ctrl_o has just updated
//   sat_o             - last update clamped the integrator or ctrl_o
//   locked_o          - loop-locked flag
module adpll_loop_filter #(
  parameter int ERR_W      = 8,
  parameter int CTRL_W     = 12,
  parameter int FRAC_W     = 8,
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 4,
  parameter int CTRL_INIT  = 2048,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4
) (
  input  logic              fpga_clk_i,
  input  logic              reset_n_i,
  input  logic              pd_valid_i,
  input  logic [ERR_W-1:0]  pd_clock_cycles_i,
  input  logic              hold_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              ctrl_valid_o,
  output logic              sat_o,
  output logic              locked_o
);

  localparam int IW = CTRL_W + FRAC_W;                          // integrator width
  localparam int SW = IW + 2;                                   // sum width: sign + guard
  localparam int PW = ERR_W + KP_SHIFT;                         // proportional term width
  localparam int OW = ((CTRL_W > PW) ? CTRL_W : PW) + 2;        // output sum width

  // Reset: assertion is asynchronous. Release passes through two flops so the
  // first active edge seen by the datapath is clean.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_reg <= 2'b00;
    else            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  // Gear select. This is high while the lock detector is in TRACK.
  logic track;

  // Stage 1: capture the sample.
  logic                    s1_valid_reg;
  logic signed [ERR_W-1:0] s1_err_reg;
  logic                    s1_hold_reg;

  always_ff @(posedge fpga_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= '0;
      s1_hold_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= pd_valid_i;
      if (pd_valid_i) begin
        s1_err_reg  <= $signed(pd_clock_cycles_i);
        s1_hold_reg <= hold_i;
      end
    end
  end

  // Stage 2: integrator and proportional term. The gains come from the lock
  // state as it was before this sample's lock update.
  logic [IW-1:0]        integ_reg;
  logic                 s2_valid_reg;
  logic signed [PW-1:0] s2_prop_reg;
  logic                 s2_isat_reg;

  logic signed [SW-1:0] err_ext;
  logic signed [SW-1:0] inc;
  logic signed [SW-1:0] integ_sum;
  logic [IW-1:0]        integ_next;
  logic                 integ_sat;
  logic signed [PW-1:0] prop;

  always_comb begin
    err_ext    = SW'(s1_err_reg);
    inc        = track ? (err_ext <<< (FRAC_W - KI_SHIFT - 1))
                       : (err_ext <<< (FRAC_W - KI_SHIFT));
    integ_sum  = $signed({2'b00, integ_reg}) + inc;
    integ_next = integ_sum[IW-1:0];
    integ_sat  = 1'b0;
    if (integ_sum[SW-1]) begin          // below zero
      integ_next = '0;
      integ_sat  = 1'b1;
    end else if (integ_sum[SW-2]) begin // above full scale
      integ_next = '1;
      integ_sat  = 1'b1;
    end
    if (s1_hold_reg) begin
      integ_next = integ_reg;
      integ_sat  = 1'b0;
    end
    prop = track ? (PW'(s1_err_reg) <<< (KP_SHIFT - 1))
                 : (PW'(s1_err_reg) <<< KP_SHIFT);
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      integ_reg    <= IW'(CTRL_INIT) << FRAC_W;
      s2_prop_reg  <= '0;
      s2_isat_reg  <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        integ_reg   <= integ_next;
        s2_prop_reg <= prop;
        s2_isat_reg <= integ_sat;
      end
    end
  end

  // Stage 3: form and clamp the control word. integ_reg already holds this
  // sample's integ_next. A following back-to-back sample only overwrites it at
  // the same edge that consumes it here.
  logic signed [OW-1:0] ctrl_sum;
  logic [CTRL_W-1:0]    ctrl_next;
  logic                 ctrl_sat;

  always_comb begin
    ctrl_sum  = $signed({{(OW-CTRL_W){1'b0}}, integ_reg[IW-1:FRAC_W]}) + OW'(s2_prop_reg);
    ctrl_next = ctrl_sum[CTRL_W-1:0];
    ctrl_sat  = 1'b0;
    if (ctrl_sum[OW-1]) begin
      ctrl_next = '0;
      ctrl_sat  = 1'b1;
    end else if (|ctrl_sum[OW-2:CTRL_W]) begin
      ctrl_next = '1;
      ctrl_sat  = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_o       <= CTRL_W'(CTRL_INIT);
      ctrl_valid_o <= 1'b0;
      sat_o        <= 1'b0;
    end else begin
      ctrl_valid_o <= s2_valid_reg;
      if (s2_valid_reg) begin
        ctrl_o <= ctrl_next;
        sat_o  <= ctrl_sat | s2_isat_reg;
      end
    end
  end

`ifdef ADPLL_LOCK_DETECT_EN
  typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} lock_state_t;

  localparam int GCW = $clog2(LOCK_COUNT + 1);
  localparam int BCW = $clog2(LOSS_COUNT + 1);

  lock_state_t           state_reg;
  logic [GCW-1:0]        good_cnt_reg;
  logic [BCW-1:0]        bad_cnt_reg;
  logic signed [ERR_W:0] err_wide;
  logic [ERR_W:0]        err_abs;
  logic                  in_window;

  // |err| is taken one bit wider, so the most negative error cannot overflow.
  always_comb begin
    err_wide  = (ERR_W+1)'(s1_err_reg);
    err_abs   = err_wide[ERR_W] ? (-err_wide) : err_wide;
    in_window = (err_abs <= (ERR_W+1)'(LOCK_TOL));
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ACQUIRE;
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else if (s1_valid_reg) begin
      case (state_reg)
        ACQUIRE: begin
          if (in_window) begin
            if (good_cnt_reg == GCW'(LOCK_COUNT - 1)) begin
              state_reg    <= TRACK;
              good_cnt_reg <= '0;
              bad_cnt_reg  <= '0;
            end else begin
              good_cnt_reg <= good_cnt_reg + 1'b1;
            end
          end else begin
            good_cnt_reg <= '0;
          end
        end
        TRACK: begin
          if (!in_window) begin
            if (bad_cnt_reg == BCW'(LOSS_COUNT - 1)) begin
              state_reg    <= ACQUIRE;
              good_cnt_reg <= '0;
              bad_cnt_reg  <= '0;
            end else begin
              bad_cnt_reg <= bad_cnt_reg + 1'b1;
            end
          end else begin
            bad_cnt_reg <= '0;
          end
        end
      endcase
    end
  end

  assign track = (state_reg == TRACK);

  // The state register already reflects this sample's lock update by stage 3.
  // As a result, the flag moves together with the sample's ctrl_valid_o.
  always_ff @(posedge fpga_clk_i or negedge rst_n) begin
    if (!rst_n)            locked_o <= 1'b0;
    else if (s2_valid_reg) locked_o <= track;
  end
`else
  assign track    = 1'b0;
  assign locked_o = 1'b0;
`endif

endmodule
